// File: rtl/switch_allocator.sv
// Router switch allocator: per-output round-robin wormhole arbitration and crossbar select.
// Optional SA_TIMEOUT_EN adds a per-output watchdog that reclaims outputs idle for 63 cycles.
module switch_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_BITS = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_PORTS-1:0]           i_req,
    input  logic [NUM_PORTS*PORT_BITS-1:0] i_dest,
    input  logic [NUM_PORTS-1:0]           i_flit_valid,
    input  logic [NUM_PORTS-1:0]           i_tail,
    output logic [NUM_PORTS-1:0]           o_ack,
    output logic [NUM_PORTS-1:0]           o_grant,
    output logic [NUM_PORTS*PORT_BITS-1:0] o_xbar_sel,
    output logic [NUM_PORTS-1:0]           o_out_busy,
    output logic [NUM_PORTS-1:0]           o_bad_dest
`ifdef SA_TIMEOUT_EN
    ,
    output logic [NUM_PORTS-1:0]           o_timeout
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [PORT_BITS:0]   NUM_PORTS_W = (PORT_BITS+1)'(NUM_PORTS);
    localparam logic [PORT_BITS-1:0] LAST_PORT   = PORT_BITS'(NUM_PORTS - 1);

    logic [0:0]           state_q  [NUM_PORTS];
    logic [PORT_BITS-1:0] holder_q [NUM_PORTS];
    logic [PORT_BITS-1:0] rr_q     [NUM_PORTS];

    logic [PORT_BITS-1:0] dest      [NUM_PORTS];
    logic [NUM_PORTS-1:0] eligible  [NUM_PORTS];
    logic [PORT_BITS-1:0] win_idx   [NUM_PORTS];
    logic [NUM_PORTS-1:0] dest_ok;
    logic [NUM_PORTS-1:0] bad_req;
    logic [NUM_PORTS-1:0] win_valid;
    logic [NUM_PORTS-1:0] release_out;
    logic [NUM_PORTS-1:0] ack_d;
    logic [NUM_PORTS-1:0] clr_d;
    logic [NUM_PORTS-1:0] timeout_d;

`ifdef SA_TIMEOUT_EN
    logic [5:0] wd_q [NUM_PORTS];
`endif

    // Request decode: an input already holding an output is not eligible anywhere.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            dest[i]    = i_dest[i*PORT_BITS +: PORT_BITS];
            dest_ok[i] = ({1'b0, dest[i]} < NUM_PORTS_W);
            bad_req[i] = i_req[i] & ~o_grant[i] & ~dest_ok[i];
        end
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                eligible[o][i] = i_req[i] & ~o_grant[i] & dest_ok[i] &
                                 (dest[i] == PORT_BITS'(o));
            end
        end
    end

    // Round-robin pick per output, starting at rr_q and wrapping modulo NUM_PORTS.
    always_comb begin
        logic [PORT_BITS:0] cand;
        cand = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            win_valid[o] = 1'b0;
            win_idx[o]   = rr_q[o];
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                cand = {1'b0, rr_q[o]} + (PORT_BITS+1)'(k);
                if (cand >= NUM_PORTS_W) begin
                    cand = cand - NUM_PORTS_W;
                end
                if (!win_valid[o] && eligible[o][cand[PORT_BITS-1:0]]) begin
                    win_valid[o] = 1'b1;
                    win_idx[o]   = cand[PORT_BITS-1:0];
                end
            end
        end
    end

    // Per-input grant set/clear, collected across all outputs.
    always_comb begin
        ack_d       = '0;
        clr_d       = '0;
        release_out = '0;
        timeout_d   = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            if (state_q[o] == IDLE) begin
                if (win_valid[o]) begin
                    ack_d[win_idx[o]] = 1'b1;
                end
            end else begin
                if (i_flit_valid[holder_q[o]] && i_tail[holder_q[o]]) begin
                    release_out[o]     = 1'b1;
                    clr_d[holder_q[o]] = 1'b1;
                end
`ifdef SA_TIMEOUT_EN
                else if (!i_flit_valid[holder_q[o]] && (wd_q[o] == 6'd63)) begin
                    timeout_d[o]       = 1'b1;
                    clr_d[holder_q[o]] = 1'b1;
                end
`endif
            end
        end
    end

    always_comb begin
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            o_out_busy[o]                        = (state_q[o] == BUSY);
            o_xbar_sel[o*PORT_BITS +: PORT_BITS] = holder_q[o];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_ack      <= '0;
            o_grant    <= '0;
            o_bad_dest <= '0;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                state_q[o]  <= IDLE;
                holder_q[o] <= '0;
                rr_q[o]     <= '0;
            end
        end else begin
            o_ack      <= ack_d;
            o_grant    <= (o_grant & ~clr_d) | ack_d;
            o_bad_dest <= o_bad_dest | bad_req;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                if (state_q[o] == IDLE) begin
                    if (win_valid[o]) begin
                        state_q[o]  <= BUSY;
                        holder_q[o] <= win_idx[o];
                        rr_q[o]     <= (win_idx[o] == LAST_PORT) ? '0 : win_idx[o] + 1'b1;
                    end
                end else if (release_out[o] || timeout_d[o]) begin
                    state_q[o] <= IDLE;
                end
            end
        end
    end

`ifdef SA_TIMEOUT_EN
    // Watchdog restarts on every holder flit; expiry is handled like a release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_timeout <= '0;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                wd_q[o] <= '0;
            end
        end else begin
            o_timeout <= timeout_d;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                if (state_q[o] == IDLE) begin
                    wd_q[o] <= '0;
                end else if (i_flit_valid[holder_q[o]] || timeout_d[o]) begin
                    wd_q[o] <= '0;
                end else begin
                    wd_q[o] <= wd_q[o] + 6'd1;
                end
            end
        end
    end
`endif

endmodule
